// File: rtl/sram_2p_pkg.sv
// Shared definitions for the two-port synchronous memory model: default base
// address and controller state encoding.
package sram_2p_pkg;

  localparam logic [63:0] PC_START = 64'h0000_0000_8000_0000;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/sram_2p_if.sv
// Request/response bundle for both memory ports: port A fetch reads, port B
// load/store with a byte write mask.
interface sram_2p_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
);

  logic                  a_req_valid;
  logic                  a_req_ready;
  logic [ADDR_W-1:0]     a_addr;
  logic                  a_rsp_valid;
  logic [DATA_W-1:0]     a_rdata;
  logic                  a_err;

  logic                  b_req_valid;
  logic                  b_req_ready;
  logic [ADDR_W-1:0]     b_addr;
  logic [DATA_W/8-1:0]   b_we;
  logic [DATA_W-1:0]     b_wdata;
  logic                  b_rsp_valid;
  logic [DATA_W-1:0]     b_rdata;
  logic                  b_err;

  modport master (
    output a_req_valid, a_addr,
    input  a_req_ready, a_rsp_valid, a_rdata, a_err,
    output b_req_valid, b_addr, b_we, b_wdata,
    input  b_req_ready, b_rsp_valid, b_rdata, b_err
  );

  modport slave (
    input  a_req_valid, a_addr,
    output a_req_ready, a_rsp_valid, a_rdata, a_err,
    input  b_req_valid, b_addr, b_we, b_wdata,
    output b_req_ready, b_rsp_valid, b_rdata, b_err
  );

endinterface

// File: rtl/sram_2p_rd_pipe.sv
// Response delay line: carries {valid, err, data} through RD_LAT-1 extra
// register stages behind the first read register held in the memory top.
module sram_rd_pipe #(
  parameter int DATA_W = 64,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_err,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic              out_err,
  output logic [DATA_W-1:0] out_data
);

  localparam int STAGES = RD_LAT - 1;
  localparam int W      = DATA_W + 2;

  generate
    if (STAGES == 0) begin : g_bypass
      logic unused_clk_rst_s;
      assign unused_clk_rst_s = clk ^ rst;
      assign out_valid = in_valid;
      assign out_err   = in_err;
      assign out_data  = in_data;
    end else begin : g_pipe
      logic [W-1:0] stage_d [STAGES];
      logic [W-1:0] stage_q [STAGES];

      // Shift each stage one slot toward the output.
      always_comb begin
        stage_d[0] = {in_valid, in_err, in_data};
        for (int i = 1; i < STAGES; i++) begin
          stage_d[i] = stage_q[i-1];
        end
      end

      // Stage registers; reset drops every in-flight response.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < STAGES; i++) begin
            stage_q[i] <= {W{1'b0}};
          end
        end else begin
          for (int i = 0; i < STAGES; i++) begin
            stage_q[i] <= stage_d[i];
          end
        end
      end

      assign {out_valid, out_err, out_data} = stage_q[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/sram_2p.sv
// Two-port synchronous memory model: A reads instructions, B reads or
// byte-mask writes data; optional zero-fill after reset, fixed read latency.
module sram_2p
  import sram_2p_pkg::*;
#(
  parameter int                DATA_W       = 64,
  parameter int                ADDR_W       = 64,
  parameter int                DEPTH        = 4096,
  parameter logic [ADDR_W-1:0] BASE         = ADDR_W'(PC_START),
  parameter int                RD_LAT       = 1,
  parameter int                CLEAR_ON_RST = 1
) (
  input  logic     clk,
  input  logic     rst,
  sram_2p_if.slave bus
);

  localparam int                BYTES     = DATA_W / 8;
  localparam int                OFF_BITS  = $clog2(BYTES);
  localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] BYTE_MASK = ADDR_W'(BYTES - 1);
  localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);

  // Below base, past the last word, or not word aligned.
  function automatic logic addr_bad(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] off;
    off = addr - BASE;
    return (addr < BASE) || ((off >> OFF_BITS) >= DEPTH_A) ||
           ((addr & BYTE_MASK) != {ADDR_W{1'b0}});
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] off;
    off = (addr - BASE) >> OFF_BITS;
    return off[IDX_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_w,
                                                    input logic [DATA_W-1:0] new_w,
                                                    input logic [BYTES-1:0]  be);
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int i = 0; i < BYTES; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_w[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_w[8*i +: 8];
      end
    end
    return res;
  endfunction

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  mem_q [DEPTH];

  logic               run_s;
  logic               a_acc_s, a_bad_s, b_acc_s, b_bad_s, b_wr_s;
  logic [IDX_W-1:0]   a_idx_s, b_idx_s;
  logic [DATA_W-1:0]  b_old_s;

  logic               wr_en_d;
  logic [IDX_W-1:0]   wr_idx_d;
  logic [DATA_W-1:0]  wr_word_d;

  logic               a_vld_q, a_vld_d, a_err_q, a_err_d;
  logic [DATA_W-1:0]  a_dat_q, a_dat_d;
  logic               b_vld_q, b_vld_d, b_err_q, b_err_d;
  logic [DATA_W-1:0]  b_dat_q, b_dat_d;

  logic               a_rsp_valid_s, a_rsp_err_s, b_rsp_valid_s, b_rsp_err_s;
  logic [DATA_W-1:0]  a_rsp_data_s, b_rsp_data_s;

  assign run_s   = (state_q == ST_RUN);
  assign a_acc_s = bus.a_req_valid && run_s;
  assign b_acc_s = bus.b_req_valid && run_s;
  assign a_bad_s = addr_bad(bus.a_addr);
  assign b_bad_s = addr_bad(bus.b_addr);
  // Errored addresses are steered to word 0 so the array is never indexed out of range.
  assign a_idx_s = a_bad_s ? {IDX_W{1'b0}} : addr_idx(bus.a_addr);
  assign b_idx_s = b_bad_s ? {IDX_W{1'b0}} : addr_idx(bus.b_addr);
  assign b_old_s = mem_q[b_idx_s];
  assign b_wr_s  = b_acc_s && !b_bad_s && (bus.b_we != {BYTES{1'b0}});

  // INIT walks the clear counter over every word, or lasts one cycle when fill is off.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        if ((CLEAR_ON_RST == 0) || (cnt_q == LAST_IDX)) begin
          state_d = ST_RUN;
          cnt_d   = {IDX_W{1'b0}};
        end else begin
          state_d = ST_INIT;
          cnt_d   = cnt_q + {{(IDX_W-1){1'b0}}, 1'b1};
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
        cnt_d   = cnt_q;
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = {IDX_W{1'b0}};
      end
    endcase
  end

  // Controller state and clear counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= {IDX_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Single write port: zero-fill during INIT, merged byte write from B in RUN.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_idx_d  = {IDX_W{1'b0}};
    wr_word_d = {DATA_W{1'b0}};
    if (!run_s) begin
      wr_en_d  = (CLEAR_ON_RST != 0);
      wr_idx_d = cnt_q;
    end else if (b_wr_s && !rst) begin
      wr_en_d   = 1'b1;
      wr_idx_d  = b_idx_s;
      wr_word_d = merge_bytes(b_old_s, bus.b_wdata, bus.b_we);
    end else begin
      wr_en_d   = 1'b0;
    end
  end

  // Storage array; not reset, INIT takes care of clearing when enabled.
  always_ff @(posedge clk) begin
    if (wr_en_d) begin
      mem_q[wr_idx_d] <= wr_word_d;
    end
  end

  // First read stage samples the pre-write word, giving read-before-write on both ports.
  always_comb begin
    a_vld_d = a_acc_s;
    a_err_d = a_acc_s && a_bad_s;
    b_vld_d = b_acc_s;
    b_err_d = b_acc_s && b_bad_s;
    if (a_acc_s && !a_bad_s) begin
      a_dat_d = mem_q[a_idx_s];
    end else begin
      a_dat_d = {DATA_W{1'b0}};
    end
    if (b_acc_s && !b_bad_s) begin
      b_dat_d = b_old_s;
    end else begin
      b_dat_d = {DATA_W{1'b0}};
    end
  end

  // First read register for both ports.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_vld_q <= 1'b0;
      a_err_q <= 1'b0;
      a_dat_q <= {DATA_W{1'b0}};
      b_vld_q <= 1'b0;
      b_err_q <= 1'b0;
      b_dat_q <= {DATA_W{1'b0}};
    end else begin
      a_vld_q <= a_vld_d;
      a_err_q <= a_err_d;
      a_dat_q <= a_dat_d;
      b_vld_q <= b_vld_d;
      b_err_q <= b_err_d;
      b_dat_q <= b_dat_d;
    end
  end

  sram_rd_pipe #(.DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_a_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (a_vld_q),
    .in_err    (a_err_q),
    .in_data   (a_dat_q),
    .out_valid (a_rsp_valid_s),
    .out_err   (a_rsp_err_s),
    .out_data  (a_rsp_data_s)
  );

  sram_rd_pipe #(.DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_b_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (b_vld_q),
    .in_err    (b_err_q),
    .in_data   (b_dat_q),
    .out_valid (b_rsp_valid_s),
    .out_err   (b_rsp_err_s),
    .out_data  (b_rsp_data_s)
  );

  assign bus.a_req_ready = run_s;
  assign bus.b_req_ready = run_s;
  assign bus.a_rsp_valid = a_rsp_valid_s;
  assign bus.a_err       = a_rsp_err_s;
  assign bus.a_rdata     = a_rsp_data_s;
  assign bus.b_rsp_valid = b_rsp_valid_s;
  assign bus.b_err       = b_rsp_err_s;
  assign bus.b_rdata     = b_rsp_data_s;

endmodule

// File: tb/tb_sram_2p.sv
// Directed bench for sram_2p: vector table on a 16-word RD_LAT=1 instance,
// plus reset/zero-fill sequences and a RD_LAT=3 streaming flush check.
module tb_sram_2p;

  localparam logic [63:0] B = 64'h0000_0000_8000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic rst3;
  int   total = 0;
  int   bad   = 0;

  sram_2p_if #(.DATA_W(64), .ADDR_W(64)) bus1 ();
  sram_2p_if #(.DATA_W(64), .ADDR_W(64)) bus3 ();
  sram_2p_if #(.DATA_W(64), .ADDR_W(64)) busc ();

  sram_2p #(.DATA_W(64), .ADDR_W(64), .DEPTH(16), .BASE(B), .RD_LAT(1), .CLEAR_ON_RST(1))
    dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  sram_2p #(.DATA_W(64), .ADDR_W(64), .DEPTH(16), .BASE(B), .RD_LAT(3), .CLEAR_ON_RST(1))
    dut3 (.clk(clk), .rst(rst3), .bus(bus3.slave));
  sram_2p #(.DATA_W(64), .ADDR_W(64), .DEPTH(16), .BASE(B), .RD_LAT(1), .CLEAR_ON_RST(0))
    dutc (.clk(clk), .rst(rst), .bus(busc.slave));

  typedef struct {
    logic        av;  logic [63:0] aaddr;
    logic        bv;  logic [63:0] baddr; logic [7:0] bwe; logic [63:0] bwd;
    logic        eav; logic [63:0] ead;   logic eae;
    logic        ebv; logic [63:0] ebd;   logic ebe;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive1(input logic av, input logic [63:0] aa, input logic bv,
                        input logic [63:0] ba, input logic [7:0] we, input logic [63:0] wd);
    bus1.a_req_valid = av; bus1.a_addr = aa;
    bus1.b_req_valid = bv; bus1.b_addr = ba; bus1.b_we = we; bus1.b_wdata = wd;
  endtask

  // Ready must stay low through 16 INIT cycles on dut1; dutc needs a single cycle.
  task automatic init_check1(input string tag);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk($sformatf("%s_rdy1_%0d", tag, k), {62'd0, bus1.a_req_ready, bus1.b_req_ready},
          (k == 16) ? 64'd3 : 64'd0);
      chk($sformatf("%s_rdyc_%0d", tag, k), {62'd0, busc.a_req_ready, busc.b_req_ready}, 64'd3);
    end
  endtask

  initial begin
    drive1(1'b0, 64'd0, 1'b0, 64'd0, 8'h00, 64'd0);
    bus3.a_req_valid = 1'b0; bus3.a_addr = 64'd0;
    bus3.b_req_valid = 1'b0; bus3.b_addr = 64'd0; bus3.b_we = 8'h00; bus3.b_wdata = 64'd0;
    busc.a_req_valid = 1'b0; busc.a_addr = 64'd0;
    busc.b_req_valid = 1'b0; busc.b_addr = 64'd0; busc.b_we = 8'h00; busc.b_wdata = 64'd0;
    rst  = 1'b1;
    rst3 = 1'b1;
    repeat (3) @(negedge clk);

    chk("reset_ctl1", {58'd0, bus1.a_req_ready, bus1.b_req_ready, bus1.a_rsp_valid,
                       bus1.b_rsp_valid, bus1.a_err, bus1.b_err}, 64'd0);
    chk("reset_a_rdata1", bus1.a_rdata, 64'd0);
    chk("reset_b_rdata1", bus1.b_rdata, 64'd0);
    chk("reset_ctl3", {62'd0, bus3.a_req_ready, bus3.a_rsp_valid}, 64'd0);
    chk("reset_ctlc", {62'd0, busc.a_req_ready, busc.b_req_ready}, 64'd0);

    rst  = 1'b0;
    rst3 = 1'b0;
    init_check1("init");

    //              av   aaddr     bv   baddr     bwe    bwd                     eav  ead                     eae   ebv  ebd                     ebe
    vecs[0]  = '{1'b1, B+64'd40,  1'b0, 64'd0,    8'h00, 64'd0,                  1'b1, 64'd0,                 1'b0, 1'b0, 64'd0,                 1'b0};
    vecs[1]  = '{1'b0, 64'd0,     1'b1, B+64'd8,  8'hFF, 64'h1122334455667788,   1'b0, 64'd0,                 1'b0, 1'b1, 64'd0,                 1'b0};
    vecs[2]  = '{1'b1, B+64'd8,   1'b0, 64'd0,    8'h00, 64'd0,                  1'b1, 64'h1122334455667788,  1'b0, 1'b0, 64'd0,                 1'b0};
    vecs[3]  = '{1'b0, 64'd0,     1'b1, B+64'd8,  8'h0F, 64'hAAAAAAAABBBBBBBB,   1'b0, 64'd0,                 1'b0, 1'b1, 64'h1122334455667788,  1'b0};
    vecs[4]  = '{1'b1, B+64'd8,   1'b0, 64'd0,    8'h00, 64'd0,                  1'b1, 64'h11223344BBBBBBBB,  1'b0, 1'b0, 64'd0,                 1'b0};
    vecs[5]  = '{1'b0, 64'd0,     1'b1, B+64'd24, 8'hFF, 64'd1,                  1'b0, 64'd0,                 1'b0, 1'b1, 64'd0,                 1'b0};
    vecs[6]  = '{1'b1, B+64'd24,  1'b1, B+64'd24, 8'hFF, 64'hDEAD,               1'b1, 64'd1,                 1'b0, 1'b1, 64'd1,                 1'b0};
    vecs[7]  = '{1'b1, B+64'd24,  1'b0, 64'd0,    8'h00, 64'd0,                  1'b1, 64'hDEAD,              1'b0, 1'b0, 64'd0,                 1'b0};
    vecs[8]  = '{1'b1, B-64'd8,   1'b1, B+64'd128,8'h00, 64'd0,                  1'b1, 64'd0,                 1'b1, 1'b1, 64'd0,                 1'b1};
    vecs[9]  = '{1'b1, B+64'd4,   1'b1, B+64'd4,  8'hFF, 64'hFFFFFFFFFFFFFFFF,   1'b1, 64'd0,                 1'b1, 1'b1, 64'd0,                 1'b1};
    vecs[10] = '{1'b0, 64'd0,     1'b1, B+64'd128,8'hFF, 64'h5555555555555555,   1'b0, 64'd0,                 1'b0, 1'b1, 64'd0,                 1'b1};
    vecs[11] = '{1'b1, B,         1'b1, B+64'd8,  8'h00, 64'd0,                  1'b1, 64'd0,                 1'b0, 1'b1, 64'h11223344BBBBBBBB,  1'b0};
    vecs[12] = '{1'b0, 64'd0,     1'b0, 64'd0,    8'h00, 64'd0,                  1'b0, 64'd0,                 1'b0, 1'b0, 64'd0,                 1'b0};
    vecs[13] = '{1'b1, B+64'd120, 1'b1, B+64'd120,8'h80, 64'hAB00000000000000,   1'b1, 64'd0,                 1'b0, 1'b1, 64'd0,                 1'b0};
    vecs[14] = '{1'b1, B+64'd120, 1'b1, B-64'd8,  8'hFF, 64'h1234,               1'b1, 64'hAB00000000000000,  1'b0, 1'b1, 64'd0,                 1'b1};
    vecs[15] = '{1'b1, B+64'd12,  1'b0, 64'd0,    8'h00, 64'd0,                  1'b1, 64'd0,                 1'b1, 1'b0, 64'd0,                 1'b0};

    for (int i = 0; i < 16; i++) begin
      drive1(vecs[i].av, vecs[i].aaddr, vecs[i].bv, vecs[i].baddr, vecs[i].bwe, vecs[i].bwd);
      @(negedge clk);
      chk($sformatf("vec%0d_a_valid", i), {63'd0, bus1.a_rsp_valid}, {63'd0, vecs[i].eav});
      chk($sformatf("vec%0d_a_rdata", i), bus1.a_rdata, vecs[i].ead);
      chk($sformatf("vec%0d_a_err", i),   {63'd0, bus1.a_err},       {63'd0, vecs[i].eae});
      chk($sformatf("vec%0d_b_valid", i), {63'd0, bus1.b_rsp_valid}, {63'd0, vecs[i].ebv});
      chk($sformatf("vec%0d_b_rdata", i), bus1.b_rdata, vecs[i].ebd);
      chk($sformatf("vec%0d_b_err", i),   {63'd0, bus1.b_err},       {63'd0, vecs[i].ebe});
    end

    // Dirty word 5, reset mid-operation, and confirm the zero-fill ran again.
    drive1(1'b0, 64'd0, 1'b1, B+64'd40, 8'hFF, 64'h55);
    @(negedge clk);
    drive1(1'b1, B+64'd40, 1'b0, 64'd0, 8'h00, 64'd0);
    @(negedge clk);
    chk("dirty_w5", bus1.a_rdata, 64'h55);
    drive1(1'b1, B+64'd40, 1'b0, 64'd0, 8'h00, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_flush_a_valid", {63'd0, bus1.a_rsp_valid}, 64'd0);
    chk("rst_ready", {62'd0, bus1.a_req_ready, bus1.b_req_ready}, 64'd0);
    drive1(1'b0, 64'd0, 1'b0, 64'd0, 8'h00, 64'd0);
    rst = 1'b0;
    init_check1("reinit");
    drive1(1'b1, B+64'd40, 1'b0, 64'd0, 8'h00, 64'd0);
    @(negedge clk);
    chk("cleared_w5_valid", {63'd0, bus1.a_rsp_valid}, 64'd1);
    chk("cleared_w5_data", bus1.a_rdata, 64'd0);
    drive1(1'b0, 64'd0, 1'b0, 64'd0, 8'h00, 64'd0);

    // RD_LAT=3: load words 0..7, then stream reads and reset mid-stream.
    for (int k = 0; k < 8; k++) begin
      bus3.b_req_valid = 1'b1; bus3.b_addr = B + 64'(8*k); bus3.b_we = 8'hFF;
      bus3.b_wdata = 64'h100 + 64'(k);
      @(negedge clk);
    end
    bus3.b_req_valid = 1'b0; bus3.b_we = 8'h00;
    repeat (3) @(negedge clk);

    for (int n = 0; n <= 8; n++) begin
      chk($sformatf("lat3_n%0d_valid", n), {63'd0, bus3.a_rsp_valid},
          (n >= 3 && n <= 6) ? 64'd1 : 64'd0);
      chk($sformatf("lat3_n%0d_rdata", n), bus3.a_rdata,
          (n >= 3 && n <= 6) ? (64'h100 + 64'(n - 3)) : 64'd0);
      chk($sformatf("lat3_n%0d_ready", n), {63'd0, bus3.a_req_ready},
          (n <= 6) ? 64'd1 : 64'd0);
      bus3.a_req_valid = (n < 6);
      bus3.a_addr      = B + 64'(8*n);
      rst3             = (n == 6 || n == 7);
      if (n < 8) @(negedge clk);
    end

    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk($sformatf("lat3_init_rdy%0d", k), {63'd0, bus3.a_req_ready}, (k == 16) ? 64'd1 : 64'd0);
      chk($sformatf("lat3_init_rsp%0d", k), {63'd0, bus3.a_rsp_valid}, 64'd0);
    end

    bus3.a_req_valid = 1'b1;
    bus3.a_addr      = B + 64'd16;
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      bus3.a_req_valid = 1'b0;
      chk($sformatf("lat3_w2_valid%0d", j), {63'd0, bus3.a_rsp_valid}, (j == 3) ? 64'd1 : 64'd0);
    end
    chk("lat3_w2_cleared", bus3.a_rdata, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_2p.md
# sram_2p

Parametrised two-port synchronous memory model for the core's simulation top: port A serves instruction fetch (read-only), port B serves load/store (read or byte-masked write). It generalises the single-port 64-bit memory with configurable width, depth, base address and read latency. It adds valid/ready request handshakes, response valids, out-of-range/misalignment error reporting, and an optional post-reset zero-fill sequence.

## Interface
- DATA_W, 64, data width in bits; multiple of 8, power of two.
- ADDR_W, 64, byte-address width.
- DEPTH, 4096, number of DATA_W-bit words.
- BASE, `PC_START, byte address of word 0.
- RD_LAT, 1, request-to-response latency in cycles, 1..4.
- CLEAR_ON_RST, 1, zero-fill all words after reset when 1.

- clk  in  1  clock, all logic rising-edge.
- rst  in  1  reset, synchronous, active-high.
- a_req_valid  in  1  port A read request.
- a_req_ready  out  1  port A can accept.
- a_addr  in  ADDR_W  port A byte address.
- a_rsp_valid  out  1  port A response strobe.
- a_rdata  out  DATA_W  port A read data.
- a_err  out  1  port A request was out of range or misaligned.
- b_req_valid  in  1  port B request.
- b_req_ready  out  1  port B can accept.
- b_addr  in  ADDR_W  port B byte address.
- b_we  in  DATA_W/8  byte write mask; all-zero = read.
- b_wdata  in  DATA_W  write data.
- b_rsp_valid  out  1  port B response strobe.
- b_rdata  out  DATA_W  port B data (pre-write contents for writes).
- b_err  out  1  port B request was out of range or misaligned.

## Operation
- FSM: INIT, RUN. rst forces INIT with clear counter 0. INIT with CLEAR_ON_RST=1 writes zero to word[cnt] each cycle, cnt+1; after word DEPTH-1 go to RUN. With CLEAR_ON_RST=0, INIT lasts exactly one cycle.
- a_req_ready = b_req_ready = (state==RUN). Request accepted on valid&&ready.
- Index = (addr - BASE) >> log2(DATA_W/8), computed at ADDR_W width.
- Error when addr < BASE, or index >= DEPTH, or low log2(DATA_W/8) address bits are nonzero. An errored request returns rdata=0 and err=1, and performs no write.
- Port B write: for each set b_we[i], byte i of word is updated at the accept edge. Response carries the old word.
- Same-cycle A read and B write to the same index: A returns the old word (read-before-write). Both accepted; no arbitration stalls.
- No response backpressure; every accepted request yields exactly one response.

## Timing
- Response: rsp_valid high exactly RD_LAT cycles after the accept edge, for one cycle; rdata/err are valid only while rsp_valid is high, and are 0 otherwise.
- Back-to-back accepts every cycle give one response per cycle, in order.
- A request accepted in cycle N sees all writes accepted in cycles < N.
- Reset values: *_req_ready=0, *_rsp_valid=0, *_rdata=0, *_err=0. rst mid-operation flushes in-flight responses (no rsp_valid after the rst edge) and restarts INIT (zero-fill again if enabled).
- INIT duration: DEPTH cycles (CLEAR_ON_RST=1) or 1 cycle (0), counted from the first cycle with rst low.

## Structure
- defines.v holds `PC_START (BASE default) and the FSM state encodings. The index and error computation are local functions.
- Sub-module sram_rd_pipe (params DATA_W, RD_LAT): shift register carrying {valid, err, data}, synchronous clear on rst. It is instantiated once per port; the storage array plus the first read register stay in sram_2p.

## Test plan
- Reset, DEPTH=16, CLEAR_ON_RST=1 -> ready low for 16 cycles after rst drops, then high; reading word 5 returns 0.
- B write addr=BASE+8, we=8'hFF, wdata=64'h1122334455667788; then A read of the same address -> a_rsp_valid RD_LAT cycles later, a_rdata=64'h1122334455667788.
- B write we=8'h0F, wdata=64'hAAAAAAAA_BBBBBBBB to that word -> b_rdata shows the old value; a later read returns 64'h11223344BBBBBBBB.
- Same cycle: A read and B full write (0xDEAD) to word 3 holding 0x1 -> a_rdata=0x1; the next A read returns 0xDEAD.
- addr=BASE-8, addr=BASE+DEPTH*8, addr=BASE+4 -> err=1, rdata=0, memory unchanged.
- RD_LAT=3, continuous A reads of words 0..7, rst asserted mid-stream -> in-order responses before rst, none after; ready low until INIT completes.
